// File: rtl/rst_seq_module_pkg.sv
// ============================================================================
// Module   : rst_seq_module_pkg
// Brief    : Shared FSM encoding and counter widths for the reset sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rst_seq_module_pkg;

    localparam int C_CNT_W = 8;
    localparam int C_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_SOFT = 2'd3
    } state_e;

endpackage : rst_seq_module_pkg

`default_nettype wire

// File: rtl/rst_sync_module.sv
// ============================================================================
// Module   : rst_sync_module
// Brief    : Async-assert / sync-deassert reset synchronizer for one domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rst_sync_module #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_sync
);

    if (P_SYNC_STAGES < 2) begin : g_chk_sync_stages
        $fatal(1, "rst_sync_module: P_SYNC_STAGES must be >= 2");
    end

    logic [P_SYNC_STAGES-1:0] r_sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= {r_sync_q[P_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_sync = r_sync_q[P_SYNC_STAGES-1];

endmodule : rst_sync_module

`default_nettype wire

// File: rtl/rst_seq_module.sv
// ============================================================================
// Module   : rst_seq_module
// Brief    : UART subsystem reset consumer; releases per-block resets in order
//            with a fixed gap and re-runs the sequence on a soft request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rst_seq_module
    import rst_seq_module_pkg::*;
#(
    parameter int P_SYNC_STAGES = 2,
    parameter int P_STAGES      = 3,
    parameter int P_STAGE_GAP   = 10,
    parameter int P_SOFT_HOLD   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_soft_req,
    output logic                o_soft_ack,
    output logic [P_STAGES-1:0] o_rst_stage,
    output logic                o_ready
);

    if (P_STAGES < 1 || P_STAGES > 8) begin : g_chk_stages
        $fatal(1, "rst_seq_module: P_STAGES must be in 1..8");
    end
    if (P_STAGE_GAP < 0 || P_STAGE_GAP > 255) begin : g_chk_gap
        $fatal(1, "rst_seq_module: P_STAGE_GAP must be in 0..255");
    end
    if (P_SOFT_HOLD < 1 || P_SOFT_HOLD > 255) begin : g_chk_hold
        $fatal(1, "rst_seq_module: P_SOFT_HOLD must be in 1..255");
    end

    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(P_STAGE_GAP - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(P_SOFT_HOLD - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(P_STAGES - 1);

    state_e                r_state_q, r_state_d;
    logic [C_CNT_W-1:0]    r_cnt_q,   r_cnt_d;
    logic [C_IDX_W-1:0]    r_idx_q,   r_idx_d;
    logic [P_STAGES-1:0]   r_stage_q, r_stage_d;
    logic                  r_ready_q, r_ready_d;
    logic                  r_ack_q,   r_ack_d;
    logic                  r_req_q;
    logic                  w_sync;
    logic                  w_rise;

    rst_sync_module #(
        .P_SYNC_STAGES (P_SYNC_STAGES)
    ) u_rst_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_sync  (w_sync)
    );

    assign w_rise = i_soft_req & ~r_req_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= ST_HOLD;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_stage_q <= '1;
            r_ready_q <= 1'b0;
            r_ack_q   <= 1'b0;
            r_req_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_stage_q <= r_stage_d;
            r_ready_q <= r_ready_d;
            r_ack_q   <= r_ack_d;
            r_req_q   <= i_soft_req;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_stage_d = r_stage_q;
        r_ready_d = r_ready_q;
        r_ack_d   = 1'b0;

        case (r_state_q)
            ST_HOLD: begin
                r_cnt_d = '0;
                r_idx_d = '0;
                if (w_sync) begin
                    r_state_d = ST_SEQ;
                end
            end

            ST_SEQ: begin
                if (P_STAGE_GAP == 0) begin
                    r_stage_d = '0;
                    r_ready_d = 1'b1;
                    r_state_d = ST_RUN;
                end else if (r_cnt_q == C_GAP_LAST) begin
                    r_cnt_d = '0;
                    r_idx_d = r_idx_q + 1'b1;
                    for (int i = 0; i < P_STAGES; i++) begin
                        if (r_idx_q == C_IDX_W'(i)) begin
                            r_stage_d[i] = 1'b0;
                        end
                    end
                    // Ready rises on the same edge as the final release.
                    if (r_idx_q == C_LAST_IDX) begin
                        r_ready_d = 1'b1;
                        r_state_d = ST_RUN;
                    end
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_rise) begin
                    r_stage_d = '1;
                    r_ready_d = 1'b0;
                    r_cnt_d   = '0;
                    r_state_d = ST_SOFT;
                end
            end

            ST_SOFT: begin
                if (r_cnt_q == C_HOLD_LAST) begin
                    r_cnt_d   = '0;
                    r_idx_d   = '0;
                    r_ack_d   = 1'b1;
                    r_state_d = ST_SEQ;
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end

            default: begin
                r_state_d = ST_HOLD;
            end
        endcase
    end

    assign o_rst_stage = r_stage_q;
    assign o_ready     = r_ready_q;
    assign o_soft_ack  = r_ack_q;

endmodule : rst_seq_module

`default_nettype wire
